// File: rtl/bcd_addsub_serial_pkg.sv
// Shared definitions for the serial BCD adder/subtractor.
// Holds BCD digit constants, the controller state encoding and the
// nines-complement helper used when preparing a subtrahend.
package bcd_pkg;

  localparam int unsigned BCD_W    = 4;
  localparam logic [3:0]  BCD_MAX  = 4'd9;
  localparam logic [3:0]  BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Nines complement of one BCD digit; result is meaningless for digits > 9.
  function automatic logic [3:0] nines_comp(input logic [3:0] digit);
    return BCD_MAX - digit;
  endfunction

endpackage

// File: rtl/bcd_addsub_serial_if.sv
// Operand/result handshake bundle for bcd_addsub_serial.
// master: operand producer and result consumer.
// slave:  the adder/subtractor itself.
// Ports: in_valid/in_ready, a_in, b_in, cin_in, sub_in (operand side);
//        out_valid/out_ready, sum_out, cout_out, invalid_out (result side).
interface bcd_addsub_serial_if #(
  parameter int unsigned N = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [4*N-1:0]   a_in;
  logic [4*N-1:0]   b_in;
  logic             cin_in;
  logic             sub_in;
  logic             out_valid;
  logic             out_ready;
  logic [4*N-1:0]   sum_out;
  logic             cout_out;
  logic             invalid_out;

  modport master (
    output in_valid, a_in, b_in, cin_in, sub_in, out_ready,
    input  in_ready, out_valid, sum_out, cout_out, invalid_out
  );

  modport slave (
    input  in_valid, a_in, b_in, cin_in, sub_in, out_ready,
    output in_ready, out_valid, sum_out, cout_out, invalid_out
  );
endinterface

// File: rtl/bcd_addsub_serial_digit_addc.sv
// One-digit BCD adder with decimal correction (purely combinational).
// Ports: a, b (BCD digits), cin (carry in) -> s (BCD digit), cout (carry out).
module bcd_digit_addc
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] t;

  assign t = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

  always_comb begin
    s    = t[3:0];
    cout = 1'b0;
    if (t > {1'b0, BCD_MAX}) begin
      // (t + 6) mod 16 only needs the low nibble of t.
      s    = t[3:0] + BCD_CORR;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Serial N-digit packed-BCD adder/subtractor, P digits per clock.
// Subtraction is A + nines(B) + ~cin; the final carry is inverted into a
// borrow. Operands flagged invalid still run full latency but report zero.
// Ports: clk, rst (sync, active high), bus (slave side of
//        bcd_addsub_serial_if: operand and result valid/ready handshakes).
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned P = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_addsub_serial_if.slave   bus
);

  localparam int unsigned Width  = BCD_W * N;
  localparam int unsigned SliceW = BCD_W * P;
  localparam int unsigned Steps  = N / P;
  localparam int unsigned CntW   = (Steps > 1) ? $clog2(Steps) : 1;

  state_e             state_q, state_d;
  logic [Width-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [Width-1:0]   sum_q, sum_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               carry_q, carry_d, sub_q, sub_d, inv_q, inv_d;
  logic               cout_q, cout_d, invalid_q, invalid_d, out_valid_q, out_valid_d;

  // Operand preparation at acceptance.
  logic [Width-1:0]   b_cap;
  logic               inv_cap;

  always_comb begin
    b_cap   = '0;
    inv_cap = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      b_cap[BCD_W*i +: BCD_W] = bus.sub_in ? nines_comp(bus.b_in[BCD_W*i +: BCD_W])
                                           : bus.b_in[BCD_W*i +: BCD_W];
      inv_cap = inv_cap | (bus.a_in[BCD_W*i +: BCD_W] > BCD_MAX)
                        | (bus.b_in[BCD_W*i +: BCD_W] > BCD_MAX);
    end
  end

  // P chained digit adders over the lowest digits of the shifting operands.
  logic [P:0]         chain;
  logic [SliceW-1:0]  dig;
  logic [Width-1:0]   dig_top;

  assign chain[0] = carry_q;

  for (genvar g = 0; g < int'(P); g++) begin : gen_digit
    bcd_digit_addc u_digit (
      .a    (a_q[BCD_W*g +: BCD_W]),
      .b    (b_q[BCD_W*g +: BCD_W]),
      .cin  (chain[g]),
      .s    (dig[BCD_W*g +: BCD_W]),
      .cout (chain[g+1])
    );
  end

  // New digits enter at the top so digit 0 ends up in bits [3:0].
  assign dig_top = Width'(dig) << (Width - SliceW);

  assign bus.in_ready    = (state_q == StIdle) && !rst;
  assign bus.out_valid   = out_valid_q;
  assign bus.sum_out     = sum_q;
  assign bus.cout_out    = cout_q;
  assign bus.invalid_out = invalid_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    inv_d       = inv_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    invalid_d   = invalid_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a_in;
          b_d     = b_cap;
          carry_d = bus.sub_in ? ~bus.cin_in : bus.cin_in;
          sub_d   = bus.sub_in;
          inv_d   = inv_cap;
          res_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> SliceW;
        b_d     = b_q >> SliceW;
        res_d   = (res_q >> SliceW) | dig_top;
        carry_d = chain[P];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(Steps - 1)) begin
          sum_d       = inv_q ? '0 : res_d;
          cout_d      = inv_q ? 1'b0 : (chain[P] ^ sub_q);
          invalid_d   = inv_q;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      inv_q       <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      invalid_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      inv_q       <= inv_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      invalid_q   <= invalid_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Bench for bcd_addsub_serial: three instances (P=1,2,4, N=4) share one
// stimulus and are checked against a table of hand-computed results.
module tb_bcd_addsub_serial;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        inv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        cin_in = 1'b0;
  logic        sub_in = 1'b0;
  logic        out_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_addsub_serial_if #(.N(4)) if_p1 ();
  bcd_addsub_serial_if #(.N(4)) if_p2 ();
  bcd_addsub_serial_if #(.N(4)) if_p4 ();

  assign if_p1.in_valid = in_valid;  assign if_p2.in_valid = in_valid;  assign if_p4.in_valid = in_valid;
  assign if_p1.a_in = a_in;          assign if_p2.a_in = a_in;          assign if_p4.a_in = a_in;
  assign if_p1.b_in = b_in;          assign if_p2.b_in = b_in;          assign if_p4.b_in = b_in;
  assign if_p1.cin_in = cin_in;      assign if_p2.cin_in = cin_in;      assign if_p4.cin_in = cin_in;
  assign if_p1.sub_in = sub_in;      assign if_p2.sub_in = sub_in;      assign if_p4.sub_in = sub_in;
  assign if_p1.out_ready = out_ready; assign if_p2.out_ready = out_ready; assign if_p4.out_ready = out_ready;

  bcd_addsub_serial #(.N(4), .P(1)) u_p1 (.clk(clk), .rst(rst), .bus(if_p1));
  bcd_addsub_serial #(.N(4), .P(2)) u_p2 (.clk(clk), .rst(rst), .bus(if_p2));
  bcd_addsub_serial #(.N(4), .P(4)) u_p4 (.clk(clk), .rst(rst), .bus(if_p4));

  logic [2:0]  ov, ir, co, iv;
  logic [15:0] so [3];
  assign ov = {if_p4.out_valid, if_p2.out_valid, if_p1.out_valid};
  assign ir = {if_p4.in_ready, if_p2.in_ready, if_p1.in_ready};
  assign co = {if_p4.cout_out, if_p2.cout_out, if_p1.cout_out};
  assign iv = {if_p4.invalid_out, if_p2.invalid_out, if_p1.invalid_out};
  assign so[0] = if_p1.sum_out;
  assign so[1] = if_p2.sum_out;
  assign so[2] = if_p4.sum_out;

  int exp_lat [3] = '{4, 2, 1};
  int p_val   [3] = '{1, 2, 4};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one operand set to all instances and check results and latency.
  task automatic run_op(input string tag, input vec_t v);
    int          lat [3];
    logic [15:0] gs  [3];
    logic        gc  [3];
    logic        gi  [3];
    @(negedge clk);
    check($sformatf("%s in_ready", tag), {29'd0, ir}, 32'h7);
    a_in = v.a; b_in = v.b; cin_in = v.cin; sub_in = v.sub; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble inputs: only the acceptance edge may sample them.
    a_in = 16'hFFFF; b_in = 16'hFFFF; cin_in = ~v.cin; sub_in = ~v.sub;
    for (int k = 0; k < 3; k++) begin
      lat[k] = 0; gs[k] = '0; gc[k] = 1'b0; gi[k] = 1'b0;
    end
    for (int cyc = 1; cyc <= 10; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        if (lat[k] == 0 && ov[k]) begin
          lat[k] = cyc - 1;
          gs[k] = so[k]; gc[k] = co[k]; gi[k] = iv[k];
        end
      end
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s P%0d latency", tag, p_val[k]), lat[k], exp_lat[k]);
      check($sformatf("%s P%0d sum", tag, p_val[k]), {16'd0, gs[k]}, {16'd0, v.sum});
      check($sformatf("%s P%0d cout", tag, p_val[k]), {31'd0, gc[k]}, {31'd0, v.cout});
      check($sformatf("%s P%0d invalid", tag, p_val[k]), {31'd0, gi[k]}, {31'd0, v.inv});
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [10];
  vec_t v;
  int   seen;

  initial begin
    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{16'h5000, 16'h1234, 1'b0, 1'b1, 16'h3766, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[6] = '{16'h1000, 16'h0999, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[8] = '{16'h0450, 16'h0550, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[9] = '{16'h0123, 16'h0123, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready low", {29'd0, ir}, 32'h0);
    check("reset out_valid", {29'd0, ov}, 32'h0);
    check("reset sum", {16'd0, so[0]}, 32'h0);
    check("reset cout/invalid", {26'd0, co, iv}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle in_ready", {29'd0, ir}, 32'h7);

    for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: hold results in DONE with out_ready low.
    out_ready = 1'b0;
    @(negedge clk);
    a_in = 16'h1234; b_in = 16'h5678; cin_in = 1'b0; sub_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in = 16'h4444; b_in = 16'h3333; cin_in = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 10 && seen == 0; cyc++) begin
      @(posedge clk);
      #1;
      if (ov[0]) seen = 1;
    end
    check("bp out_valid reached", seen, 1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp hold%0d sum", c), {16'd0, so[0]}, 32'h6912);
      check($sformatf("bp hold%0d valid/ready", c), {30'd0, ov[0], ir[0]}, 32'h2);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release out_valid", {29'd0, ov}, 32'h0);
    check("bp release in_ready", {29'd0, ir}, 32'h7);
    check("bp retained sum", {16'd0, so[0]}, 32'h6912);
    run_op("bp back-to-back", vecs[1]);

    // Reset during RUN aborts the operation.
    @(negedge clk);
    a_in = 16'h1234; b_in = 16'h5678; cin_in = 1'b0; sub_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst mid-run out_valid", {29'd0, ov}, 32'h0);
    check("rst mid-run sum P1", {16'd0, so[0]}, 32'h0);
    check("rst mid-run sum P4", {16'd0, so[2]}, 32'h0);
    check("rst mid-run cout/invalid", {26'd0, co, iv}, 32'h0);
    check("rst mid-run in_ready", {29'd0, ir}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (ov != 3'b000) seen = 1;
    end
    check("rst abort no out_valid", seen, 0);
    check("rst abort idle", {29'd0, ir}, 32'h7);
    run_op("after reset", vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
